// File: rtl/systolic_drain_pkg.sv
// Shared types and defaults for the systolic array and its result drain stage.
// Optional feature macro: SYSTOLIC_DRAIN_RELU_EN (ReLU on drained elements).
package systolic_drain_pkg;

  localparam int unsigned DRAIN_DATA_BITS  = 16;
  localparam int unsigned DRAIN_ARRAY_SIZE = 4;
  localparam int unsigned DRAIN_NUM_ELEMS  = DRAIN_ARRAY_SIZE * DRAIN_ARRAY_SIZE;
  localparam int unsigned DRAIN_IDX_BITS   = $clog2(DRAIN_NUM_ELEMS);

  typedef logic signed [15:0] q115_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_STREAM,
    S_DONE
  } drain_state_e;

  // Negative Q1.15 values clamp to zero; non-negative values pass unchanged.
  function automatic q115_t q115_relu(input q115_t x);
    return x[15] ? q115_t'(16'h0000) : x;
  endfunction

endpackage

// File: rtl/systolic_drain_if.sv
// Valid/ready element stream carrying drained results with index and last flag.
interface systolic_drain_if
  import systolic_drain_pkg::*;
#(
  parameter int unsigned DATA_BITS = DRAIN_DATA_BITS,
  parameter int unsigned IDX_BITS  = DRAIN_IDX_BITS
);

  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  logic [IDX_BITS-1:0]  out_index;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/systolic_drain.sv
// Snapshots the systolic array result bus and streams it out row-major, one element per cycle.
// Optional feature macro: SYSTOLIC_DRAIN_RELU_EN (apply ReLU to each streamed element).
module systolic_drain
  import systolic_drain_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DRAIN_DATA_BITS,
  parameter int unsigned ARRAY_SIZE = DRAIN_ARRAY_SIZE
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic                                         array_ready,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_BITS-1:0]   results,
  output logic                                         clear_acc,
  output logic                                         busy,
  output logic                                         done,
  systolic_drain_if.master                             out_if
);

  localparam int unsigned NUM_ELEMS = ARRAY_SIZE * ARRAY_SIZE;
  localparam int unsigned IDX_BITS  = $clog2(NUM_ELEMS);
  localparam int unsigned BUS_BITS  = NUM_ELEMS * DATA_BITS;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_ELEMS - 1);

  drain_state_e         state_q, state_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic [BUS_BITS-1:0]  snap_q, snap_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic [IDX_BITS-1:0]  out_index_q, out_index_d;
  logic                 out_last_q, out_last_d;
  logic                 clear_acc_q, clear_acc_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 capture;
  logic                 load;
  logic [BUS_BITS-1:0]  src_bus;
  logic [DATA_BITS-1:0] elem;
  logic [DATA_BITS-1:0] elem_out;

  // Next-state, index and registered-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    capture     = 1'b0;
    load        = 1'b0;
    src_bus     = snap_q;
    elem        = '0;
    elem_out    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (array_ready) begin
            capture = 1'b1;
            state_d = S_STREAM;
          end else begin
            state_d = S_WAIT_RDY;
          end
        end
      end
      S_WAIT_RDY: begin
        if (array_ready) begin
          capture = 1'b1;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (out_valid_q && out_if.out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d       = '0;
            out_index_d = '0;
            out_last_d  = 1'b0;
            state_d     = S_DONE;
          end else begin
            idx_d = idx_q + IDX_BITS'(1);
            load  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The first element comes straight off the bus being captured.
    if (capture) begin
      snap_d  = results;
      src_bus = results;
      idx_d   = '0;
      load    = 1'b1;
    end

    if (load) begin
      elem = src_bus[32'(idx_d) * DATA_BITS +: DATA_BITS];
`ifdef SYSTOLIC_DRAIN_RELU_EN
      elem_out = DATA_BITS'(q115_relu(q115_t'(elem)));
`else
      elem_out = elem;
`endif
      out_data_d  = elem_out;
      out_index_d = idx_d;
      out_last_d  = (idx_d == LAST_IDX);
    end
  end

  assign out_valid_d = (state_d == S_STREAM);
  assign clear_acc_d = capture;
  assign done_d      = (state_d == S_DONE);
  assign busy_d      = (state_d != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      snap_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      clear_acc_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      clear_acc_q <= clear_acc_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_index = out_index_q;
  assign out_if.out_last  = out_last_q;
  assign clear_acc        = clear_acc_q;
  assign done             = done_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed scoreboard bench for systolic_drain; expectations follow SYSTOLIC_DRAIN_RELU_EN.
module tb_systolic_drain;
  import systolic_drain_pkg::*;

  localparam int unsigned NE = 16;
  localparam int unsigned DW = 16;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  index;
    logic        last;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             array_ready;
  logic [NE*DW-1:0] results;
  logic             clear_acc;
  logic             busy;
  logic             done;

  systolic_drain_if out_if ();

  systolic_drain dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .array_ready (array_ready),
    .results     (results),
    .clear_acc   (clear_acc),
    .busy        (busy),
    .done        (done),
    .out_if      (out_if)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          clr_cnt = 0;
  int          done_cnt = 0;
  exp_t        sb[$];
  logic        stall_prev = 1'b0;
  logic [15:0] stall_data;
  logic [3:0]  stall_idx;

  function automatic logic [15:0] model(input logic [15:0] x);
`ifdef SYSTOLIC_DRAIN_RELU_EN
    return x[15] ? 16'h0000 : x;
`else
    return x;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_tile(input logic [NE*DW-1:0] bus);
    for (int k = 0; k < NE; k++) begin
      exp_t e;
      e.data  = model(bus[k*DW +: DW]);
      e.index = 4'(k);
      e.last  = (k == NE - 1);
      sb.push_back(e);
    end
  endtask

  // Scoreboard the handshake about to happen, check stall holding, then advance one cycle.
  task automatic tick();
    exp_t e;
    if (out_if.out_valid && out_if.out_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("data", out_if.out_data, e.data);
        check("index", out_if.out_index, e.index);
        check("last", out_if.out_last, e.last);
      end
    end
    if (stall_prev && out_if.out_valid) begin
      check("stall_data", out_if.out_data, stall_data);
      check("stall_index", out_if.out_index, stall_idx);
    end
    stall_prev = out_if.out_valid && !out_if.out_ready;
    stall_data = out_if.out_data;
    stall_idx  = out_if.out_index;
    if (clear_acc === 1'b1) clr_cnt++;
    if (done === 1'b1) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input bit rand_ready);
    int n = 0;
    int stall7 = 0;
    while (done !== 1'b1 && n < budget) begin
      if (!rand_ready) begin
        out_if.out_ready = 1'b1;
      end else if (out_if.out_valid && out_if.out_index == 4'd7) begin
        out_if.out_ready = (stall7 >= 3);
        if (stall7 < 3) stall7++;
      end else begin
        out_if.out_ready = 1'($urandom_range(0, 1));
      end
      tick();
      n++;
    end
    check("done_seen", done, 1);
    if (rand_ready) check("stall7_cycles", stall7, 3);
    out_if.out_ready = 1'b1;
    tick();
  endtask

  task automatic rand_bus(output logic [NE*DW-1:0] bus);
    for (int k = 0; k < NE; k++) bus[k*DW +: DW] = 16'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NE*DW-1:0] bus;
    int c0;
    int d0;
    int n;

    reset = 1'b1; start = 1'b0; array_ready = 1'b0; results = '0;
    out_if.out_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_valid", out_if.out_valid, 0);
    check("rst_data", out_if.out_data, 0);
    check("rst_index", out_if.out_index, 0);
    check("rst_last", out_if.out_last, 0);
    check("rst_clear", clear_acc, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    tick();

    // Full throughput with a known ramp.
    for (int k = 0; k < NE; k++) results[k*DW +: DW] = 16'(16'h0100 * k + 1);
    push_tile(results);
    start = 1'b1; array_ready = 1'b1; out_if.out_ready = 1'b1;
    c0 = clr_cnt;
    tick();
    start = 1'b0;
    check("t2_busy", busy, 1);
    for (int k = 0; k < NE; k++) begin
      check("t2_valid", out_if.out_valid, 1);
      check("t2_index", out_if.out_index, 32'(k));
      check("t2_last", out_if.out_last, 32'(k == NE - 1));
      check("t2_clear", clear_acc, 32'(k == 0));
      tick();
    end
    check("t2_done", done, 1);
    check("t2_valid_off", out_if.out_valid, 0);
    check("t2_busy_done", busy, 1);
    tick();
    check("t2_done_pulse", done, 0);
    check("t2_busy_idle", busy, 0);
    check("t2_clear_once", clr_cnt - c0, 1);
    check("t2_sb_empty", sb.size(), 0);

    // Backpressure with polarity corner values.
    rand_bus(bus);
    bus[0*DW +: DW] = 16'h8000;
    bus[1*DW +: DW] = 16'hFFFF;
    bus[2*DW +: DW] = 16'h7FFF;
    results = bus;
    push_tile(results);
    start = 1'b1; array_ready = 1'b1;
    tick();
    start = 1'b0;
    drain(200, 1'b1);
    check("t3_sb_empty", sb.size(), 0);

    // Wait for the array; the value at the array_ready edge wins.
    rand_bus(bus);
    results = bus;
    start = 1'b1; array_ready = 1'b0;
    tick();
    start = 1'b0;
    check("t4_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      rand_bus(bus);
      results = bus;
      start = (i == 1);
      check("t4_wait_valid", out_if.out_valid, 0);
      check("t4_wait_clear", clear_acc, 0);
      tick();
    end
    start = 1'b0;
    rand_bus(bus);
    results = bus;
    push_tile(results);
    array_ready = 1'b1;
    c0 = clr_cnt;
    tick();
    array_ready = 1'b0;
    rand_bus(bus);
    results = bus;
    check("t4_clear", clear_acc, 1);
    check("t4_valid", out_if.out_valid, 1);
    check("t4_index0", out_if.out_index, 0);
    drain(100, 1'b0);
    check("t4_clear_once", clr_cnt - c0, 1);
    check("t4_sb_empty", sb.size(), 0);

    // Start during streaming is ignored and the snapshot is isolated from the bus.
    rand_bus(bus);
    results = bus;
    push_tile(results);
    start = 1'b1; array_ready = 1'b1; out_if.out_ready = 1'b1;
    c0 = clr_cnt; d0 = done_cnt;
    tick();
    start = 1'b0;
    n = 0;
    while (out_if.out_index != 4'd3 && n < 20) begin
      tick();
      n++;
    end
    check("t5_reach_idx3", out_if.out_index, 3);
    start = 1'b1;
    rand_bus(bus);
    results = bus;
    tick();
    start = 1'b0;
    drain(100, 1'b0);
    check("t5_clear_once", clr_cnt - c0, 1);
    check("t5_done_once", done_cnt - d0, 1);
    check("t5_sb_empty", sb.size(), 0);
    check("t5_no_restart_busy", busy, 0);
    check("t5_no_restart_valid", out_if.out_valid, 0);

    // Reset mid-stream drops the tile.
    rand_bus(bus);
    results = bus;
    push_tile(results);
    start = 1'b1; array_ready = 1'b1; out_if.out_ready = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (out_if.out_index != 4'd5 && n < 20) begin
      tick();
      n++;
    end
    check("t6_reach_idx5", out_if.out_index, 5);
    out_if.out_ready = 1'b0;
    reset = 1'b1;
    d0 = done_cnt;
    tick();
    reset = 1'b0;
    stall_prev = 1'b0;
    sb.delete();
    check("t6_valid", out_if.out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_index", out_if.out_index, 0);
    check("t6_clear", clear_acc, 0);
    check("t6_done", done, 0);
    out_if.out_ready = 1'b1;
    repeat (5) tick();
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_idle_valid", out_if.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/systolic_drain.md
# systolic_drain

Result drain stage directly downstream of the systolic array. On a start request it snapshots the array's flattened Q1.15 result bus, pulses a one-cycle accumulator clear back to the array, and streams the ARRAY_SIZE×ARRAY_SIZE results out one element per cycle over a valid/ready interface in row-major order. It lets the array begin the next tile while the previous tile's results are still draining.

## Interface
- DATA_BITS, 16: element width; Q1.15 signed.
- ARRAY_SIZE, 4: array dimension N; N×N elements are drained.
- IDX_BITS, $clog2(ARRAY_SIZE*ARRAY_SIZE): index width; derived, not overridden.

- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request to drain the current array results.
- array_ready  in  1  array `ready`; high means the results bus is stable.
- results  in  N*N*DATA_BITS  array result bus; element (r,c) is at bits [(r*N+c)*DATA_BITS +: DATA_BITS].
- clear_acc  out  1  one-cycle pulse to the array's `clear_acc` after a snapshot.
- busy  out  1  high in any state other than IDLE.
- out_valid  out  1  out_data, out_index and out_last are valid.
- out_ready  in  1  downstream accepts the element.
- out_data  out  DATA_BITS  result element.
- out_index  out  IDX_BITS  element index r*N+c.
- out_last  out  1  high with index N*N-1.
- done  out  1  one-cycle pulse after the final handshake.

## Operation
- FSM states: IDLE, WAIT_RDY, STREAM, DONE.
- IDLE:
  - start=1 and array_ready=1: capture `results` into the snapshot register, go to STREAM.
  - start=1 and array_ready=0: go to WAIT_RDY.
- WAIT_RDY: capture and go to STREAM on the first cycle with array_ready=1. start is ignored in this state.
- STREAM:
  - out_valid=1; out_data is snapshot element[idx]; out_index=idx.
  - On a handshake (out_valid && out_ready), idx increments.
  - On the handshake at idx=N*N-1, idx wraps to 0 and the FSM goes to DONE.
- DONE: done=1 for exactly one cycle, then the FSM returns to IDLE.
- start in STREAM or DONE is ignored; requests are not queued.
- clear_acc is asserted in the cycle after every capture and only then.
- Stall rule: while out_valid=1 and out_ready=0, out_data, out_index and out_last hold unchanged. out_valid never drops before its handshake.
- Elements are passed bit-exact; the drain does no rescaling or saturation (the array has already saturated them).
- reset in any state, including mid-stream:
  - FSM goes to IDLE; idx=0.
  - out_valid, clear_acc, done and busy go to 0.
  - The snapshot register is cleared to 0.
  - An in-flight tile is dropped without a done pulse.

## Timing
- Reset values: busy=0, out_valid=0, out_data=0, out_index=0, out_last=0, clear_acc=0, done=0.
- Timing for start=1 and array_ready=1 sampled at edge t:
  - Capture happens at edge t.
  - clear_acc=1, out_valid=1 and out_index=0 during cycle t..t+1.
- With out_ready held high there is one element per cycle: index k is presented in cycle t+k, the final handshake is at edge t+N*N, and done=1 in the following cycle.
- busy is high from the cycle after the capturing or WAIT_RDY-entry edge through the DONE cycle inclusive.
- A new start is accepted in the cycle after DONE, at the earliest.
- Outputs are registered; there is no combinational path from out_ready to out_valid. out_data may be a registered mux of the snapshot.

## Configuration
- SYSTOLIC_DRAIN_RELU_EN
  - Defined: each element with sign bit 1 is output as 0 (ReLU); non-negative elements pass unchanged. The snapshot itself is unaltered.
  - Undefined: pure pass-through.
- Handshake timing is identical in both builds.

## Structure
- Shared package (e.g. systolic_pkg) holds:
  - DATA_BITS and ARRAY_SIZE defaults, also used by systolic_array;
  - the Q1.15 type;
  - the drain FSM state enum.
- Single module; no sub-module is required.
- The ReLU, when enabled, is an inline function in the package (q115_relu).

## Test plan
- Reset mid-stream: assert reset at index 5 -> next cycle out_valid=0, busy=0, out_index=0; no done pulse.
- Back-to-back full throughput: results element k = 16'h0100*k+1, out_ready=1, start with array_ready=1 -> outputs 0x0001, 0x0101 … 0x0F01 on consecutive cycles with indices 0..15; out_last only at 15; clear_acc once, in the cycle after capture; done in the cycle after index 15.
- Backpressure: toggle out_ready randomly and hold it low 3 cycles at index 7 -> data and index held at 7 throughout the stall; all 16 elements delivered exactly once and in order.
- Wait for array: start with array_ready=0 for 4 cycles, change `results` during the wait, then raise array_ready -> the values present at the array_ready=1 edge are captured; clear_acc 1 cycle later.
- Ignored start and snapshot isolation: pulse start at index 3, and change `results` during streaming -> no restart, no extra clear_acc, and the streamed values match the original snapshot.
- Polarity: element = 16'h8000 and 16'hFFFF -> ReLU build outputs 0x0000; pass-through build outputs 0x8000 and 0xFFFF; 16'h7FFF outputs unchanged in both builds.
